b16_dot_sequencer: RTL and testbench

- Initiator-side controller for the bfloat16 MAC datapath.
- Holds two operand vectors (A, B) in local register files, loaded by the host through a simple write port.
- On `start`, it:
  - clears the MAC accumulator,
  - streams `len` operand pairs one per cycle over the MAC `valid`/`oprA`/`oprB` interface,
  - waits out the MAC pipeline drain,
  - captures the MAC `Result` as the dot product and pulses `done`.

---
 rtl/b16_dot_sequencer_pkg.sv | 16 +
 rtl/b16_dot_sequencer_if.sv | 20 ++
 rtl/b16_dot_sequencer_vec_regfile.sv | 22 ++
 rtl/b16_dot_sequencer.sv | 122 ++++++++++++
 tb/tb_b16_dot_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/b16_dot_sequencer_pkg.sv
// Shared definitions for the bfloat16 dot-product sequencer and its MAC.
package b16_dot_sequencer_pkg;
  localparam int unsigned BF16_W        = 16;
  localparam int unsigned MAC_DRAIN_CYC = 3;

  localparam logic [BF16_W-1:0] BF16_ZERO = 16'h0000;
  localparam logic [BF16_W-1:0] BF16_ONE  = 16'h3F80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;
endpackage

// File: rtl/b16_dot_sequencer_if.sv
// MAC-side bus: accumulator clear, operand issue and result return.
interface b16_dot_sequencer_if;
  import b16_dot_sequencer_pkg::*;

  logic              mac_clr;
  logic              mac_valid;
  logic [BF16_W-1:0] mac_oprA;
  logic [BF16_W-1:0] mac_oprB;
  logic [BF16_W-1:0] mac_result;

  modport master (
    output mac_clr, mac_valid, mac_oprA, mac_oprB,
    input  mac_result
  );

  modport slave (
    input  mac_clr, mac_valid, mac_oprA, mac_oprB,
    output mac_result
  );
endinterface

// File: rtl/b16_dot_sequencer_vec_regfile.sv
// DEPTH x bfloat16 operand store: one synchronous write port, one combinational read port.
module b16_vec_regfile
  import b16_dot_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BF16_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BF16_W-1:0] rdata
);
  logic [BF16_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/b16_dot_sequencer.sv
// Dot-product initiator: clears the MAC, streams len operand pairs, waits out the
// MAC pipeline and captures the accumulated result.
module b16_dot_sequencer
  import b16_dot_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DRAIN_CYC = MAC_DRAIN_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [BF16_W-1:0]          wr_data,
  input  logic                       start,
  input  logic [ADDR_W:0]            len,
  output logic                       busy,
  output logic                       done,
  output logic [BF16_W-1:0]          dot_result,
  b16_dot_sequencer_if.master        mac
);
  localparam int unsigned CNT_W = $clog2(DRAIN_CYC + 1);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_eff;
  logic [CNT_W-1:0]  drain_cnt;
  logic              wr_ok;
  logic [BF16_W-1:0] rd_a;
  logic [BF16_W-1:0] rd_b;

  assign wr_ok   = wr_en && (state == S_IDLE) && !start;
  assign len_eff = (len > LEN_MAX) ? LEN_MAX : len;

  b16_vec_regfile #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_vec_a (
    .clk   (clk),
    .we    (wr_ok && !wr_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx[ADDR_W-1:0]),
    .rdata (rd_a)
  );

  b16_vec_regfile #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_vec_b (
    .clk   (clk),
    .we    (wr_ok && wr_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx[ADDR_W-1:0]),
    .rdata (rd_b)
  );

  // idx always points at the next pair to present, so the pair is registered
  // onto the bus on the same edge idx advances past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      len_q          <= '0;
      drain_cnt      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      dot_result     <= BF16_ZERO;
      mac.mac_clr    <= 1'b0;
      mac.mac_valid  <= 1'b0;
      mac.mac_oprA   <= BF16_ZERO;
      mac.mac_oprB   <= BF16_ZERO;
    end else begin
      done        <= 1'b0;
      mac.mac_clr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_CLEAR;
            len_q       <= len_eff;
            idx         <= '0;
            busy        <= 1'b1;
            mac.mac_clr <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (len_q != '0) begin
            state         <= S_ISSUE;
            mac.mac_valid <= 1'b1;
            mac.mac_oprA  <= rd_a;
            mac.mac_oprB  <= rd_b;
            idx           <= idx + 1'b1;
          end else begin
            state     <= S_DRAIN;
            drain_cnt <= CNT_W'(DRAIN_CYC);
          end
        end
        S_ISSUE: begin
          if (idx == len_q) begin
            state         <= S_DRAIN;
            mac.mac_valid <= 1'b0;
            drain_cnt     <= CNT_W'(DRAIN_CYC);
          end else begin
            mac.mac_oprA <= rd_a;
            mac.mac_oprB <= rd_b;
            idx          <= idx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt <= CNT_W'(1)) begin
            state      <= S_DONE;
            dot_result <= mac.mac_result;
            done       <= 1'b1;
            busy       <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_b16_dot_sequencer.sv
// Bench for b16_dot_sequencer with a behavioural 3-stage bfloat16 MAC.
module tb_b16_dot_sequencer;
  import b16_dot_sequencer_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam logic [15:0] JUNK   = 16'h4480;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic [15:0]       dot_result;

  int errs   = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  b16_dot_sequencer_if mac_bus();

  b16_dot_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DRAIN_CYC(MAC_DRAIN_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .dot_result (dot_result),
    .mac        (mac_bus.master)
  );

  always #5 clk = ~clk;

  function automatic real bf2r(input logic [15:0] x);
    real v;
    int  e;
    e = int'(x[14:7]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(x[6:0]) / 128.0;
    while (e > 127) begin v = v * 2.0; e--; end
    while (e < 127) begin v = v / 2.0; e++; end
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    real        v;
    int         e;
    logic       s;
    logic [6:0] m;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    v = s ? -r : r;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m = 7'($rtoi((v - 1.0) * 128.0));
    return {s, 8'(e), m};
  endfunction

  // MAC model: product register, accumulate, output register.
  real  prod_r;
  real  acc_r;
  logic prod_v;
  always @(posedge clk) begin
    if (rst || mac_bus.mac_clr) begin
      prod_v             <= 1'b0;
      prod_r             <= 0.0;
      acc_r              <= 0.0;
      mac_bus.mac_result <= 16'h0000;
    end else begin
      prod_v             <= mac_bus.mac_valid;
      prod_r             <= bf2r(mac_bus.mac_oprA) * bf2r(mac_bus.mac_oprB);
      if (prod_v) acc_r  <= acc_r + prod_r;
      mac_bus.mac_result <= r2bf(acc_r);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done: got done=1 with dot_result=%0h expected no done", dot_result);
      end else begin
        exp_v = exp_q.pop_front();
        chk("dot_result", 32'(dot_result), 32'(exp_v));
      end
    end
  end

  task automatic wr(input logic sel, input int unsigned addr, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = ADDR_W'(addr);
    wr_data = data;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic load_vecs(input int unsigned n, input logic [15:0] a, input logic [15:0] b);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr(1'b0, i, (i < n) ? a : JUNK);
      wr(1'b1, i, (i < n) ? b : JUNK);
    end
  endtask

  task automatic run_dot(input logic [ADDR_W:0] l, input logic [15:0] exp_res,
                         input int exp_lat, input int n_issue,
                         input bit inject, input bit coinc_wr);
    int cyc, clr_n, val_n, first_val;
    bit got;
    exp_q.push_back(exp_res);
    start = 1'b1;
    len   = l;
    if (coinc_wr) begin
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = '0; wr_data = JUNK;
    end
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc = 0; clr_n = 0; val_n = 0; first_val = -1; got = 1'b0;
    while (cyc < 64) begin
      if (mac_bus.mac_clr) clr_n++;
      if (mac_bus.mac_valid) begin
        val_n++;
        if (first_val < 0) first_val = cyc;
      end
      if (done) begin got = 1'b1; break; end
      if (inject && cyc == 2) begin
        start = 1'b1; len = 5'd1;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd3; wr_data = JUNK;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    if (!got) begin
      checks++;
      errs++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done at %0d", cyc, exp_lat);
      void'(exp_q.pop_back());
    end else begin
      chk("done_latency", 32'(cyc), 32'(exp_lat));
      chk("clr_cycles", 32'(clr_n), 32'd1);
      chk("valid_cycles", 32'(val_n), 32'(n_issue));
      chk("busy_at_done", 32'(busy), 32'd0);
      if (n_issue > 0) chk("first_valid_cycle", 32'(first_val), 32'd1);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [ADDR_W:0] len;
    logic [15:0]     a_val;
    logic [15:0]     b_val;
    logic [15:0]     exp_res;
    int              exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{5'd4,  16'h3F80, 16'h4000, 16'h4100, 8};
    vecs[1] = '{5'd1,  16'h4040, 16'hC000, 16'hC0C0, 5};
    vecs[2] = '{5'd0,  16'h3F80, 16'h3F80, 16'h0000, 4};
    vecs[3] = '{5'd16, 16'h3F80, 16'h3F80, 16'h4180, 20};
    vecs[4] = '{5'd20, 16'h3F00, 16'h4000, 16'h4180, 20};
    vecs[5] = '{5'd2,  16'h4000, 16'h4040, 16'h4140, 6};
    vecs[6] = '{5'd3,  16'hBF80, 16'h3F80, 16'hC040, 7};

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dot_result", 32'(dot_result), 32'd0);
    chk("rst_mac_valid", 32'(mac_bus.mac_valid), 32'd0);
    chk("rst_mac_clr", 32'(mac_bus.mac_clr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      int n_eff;
      n_eff = (vecs[i].len > 5'd16) ? 16 : int'(vecs[i].len);
      load_vecs(n_eff, vecs[i].a_val, vecs[i].b_val);
      run_dot(vecs[i].len, vecs[i].exp_res, vecs[i].exp_lat, n_eff, 1'b0, 1'b0);
    end

    // Back-to-back: ignored start and write during busy, then a write coincident with start.
    load_vecs(4, 16'h3F80, 16'h4000);
    run_dot(5'd4, 16'h4100, 8, 4, 1'b1, 1'b0);
    wr(1'b0, 0, 16'h3F80);
    wr(1'b1, 0, 16'h3F80);
    run_dot(5'd1, 16'h3F80, 5, 1, 1'b0, 1'b1);

    // Reset during the second issue cycle.
    load_vecs(4, 16'h3F80, 16'h4000);
    start = 1'b1; len = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_issue_valid", 32'(mac_bus.mac_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_mac_valid", 32'(mac_bus.mac_valid), 32'd0);
    chk("midrst_mac_clr", 32'(mac_bus.mac_clr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_dot_result", 32'(dot_result), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    run_dot(5'd4, 16'h4100, 8, 4, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
